// File: rtl/sernor_target_io_pkg.sv
// Shared types and helpers for the serial-NOR target IO block.
// Falls back to the femto.vh direction encodings when that header is not on the include path.
`ifndef IOR_DIR_OUT
`define IOR_DIR_OUT 1'b1
`endif
`ifndef IOR_DIR_IN
`define IOR_DIR_IN 1'b0
`endif

package sernor_target_io_pkg;

    localparam logic [1:0] SERNOR_WID_1 = 2'd0;
    localparam logic [1:0] SERNOR_WID_2 = 2'd1;
    localparam logic [1:0] SERNOR_WID_4 = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_SHIFT = 2'd2
    } state_e;

    // Code 3 is an alias of the quad width.
    function automatic logic [1:0] wid_norm(input logic [1:0] w);
        logic [1:0] n;
        case (w)
            SERNOR_WID_1: n = SERNOR_WID_1;
            SERNOR_WID_2: n = SERNOR_WID_2;
            default:      n = SERNOR_WID_4;
        endcase
        return n;
    endfunction

    function automatic logic [3:0] wid_step(input logic [1:0] wn);
        logic [3:0] s;
        case (wn)
            SERNOR_WID_1: s = 4'd1;
            SERNOR_WID_2: s = 4'd2;
            default:      s = 4'd4;
        endcase
        return s;
    endfunction

    // Single-lane data leaves on lane 1 so lane 0 stays the initiator's input.
    function automatic logic [3:0] lane_map(input logic [7:0] sh, input logic [1:0] wn);
        logic [3:0] l;
        case (wn)
            SERNOR_WID_1: l = {2'b00, sh[7], 1'b0};
            SERNOR_WID_2: l = {2'b00, sh[7:6]};
            default:      l = sh[7:4];
        endcase
        return l;
    endfunction

endpackage

// File: rtl/sernor_target_io_if.sv
// SPI pad bundle between an initiator (master) and the target IO block (slave).
interface sernor_target_io_if;
    logic       spi_csn;
    logic       spi_sclk;
    logic [3:0] spi_din;
    logic [3:0] spi_dout;
    logic       spi_dir;

    modport master (output spi_csn, output spi_sclk, output spi_din,
                    input spi_dout, input spi_dir);
    modport slave  (input spi_csn, input spi_sclk, input spi_din,
                    output spi_dout, output spi_dir);
endinterface

// File: rtl/sernor_target_io_sync.sv
// Optional 2-flop synchronizer plus rise/fall detection for one SPI pin.
// Synchronizer stages are present only when SERNOR_TARGET_SYNC_EN is defined.
module sernor_sync #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rstn,
    input  logic pin,
    output logic rise,
    output logic fall
);

    logic level_s;
    logic prev_r;

`ifdef SERNOR_TARGET_SYNC_EN
    logic [1:0] sync_r;

    // Two-stage metastability filter followed by the edge-reference flop.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync_r <= {RST_VAL, RST_VAL};
            prev_r <= RST_VAL;
        end else begin
            sync_r <= {sync_r[0], pin};
            prev_r <= sync_r[1];
        end
    end

    assign level_s = sync_r[1];
`else
    // Same-clock pins: one reference flop is enough for edge detection.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            prev_r <= RST_VAL;
        end else begin
            prev_r <= pin;
        end
    end

    assign level_s = pin;
`endif

    assign rise = level_s & ~prev_r;
    assign fall = ~level_s & prev_r;

endmodule

// File: rtl/sernor_target_io.sv
// Serial-NOR target IO: 1/2/4-lane SPI byte shifter, modes 0 and 3.
// Define SERNOR_TARGET_SYNC_EN to add 2-flop synchronizers on csn, sclk and din.
module sernor_target_io #(
    parameter logic IDLE_SCLK = 1'b0
) (
    input  logic                     clk,
    input  logic                     rstn,
    sernor_target_io_if.slave        spi,
    input  logic [1:0]               wid,
    input  logic                     dir,
    output logic [7:0]               rx_data,
    output logic                     rx_valid,
    input  logic [7:0]               tx_data,
    output logic                     tx_req,
    output logic                     sel_start,
    output logic                     sel_end
);
    import sernor_target_io_pkg::*;

    logic       csn_rise_s, csn_fall_s, sclk_rise_s, sclk_fall_s;
    logic [3:0] din_s;
    state_e     state_r, state_nxt_s;
    logic       active_s, shift_s, rx_edge_s, tx_edge_s, load_s;
    logic       sel_start_s, sel_end_s, byte_end_s;
    logic [1:0] wn_s;
    logic [3:0] step_s, cnt_sum_s;
    logic [7:0] rx_nxt_s, tx_nxt_s;
    logic [2:0] cnt_r;
    logic       done_r;
    logic [7:0] rx_sh_r, tx_sh_r, rx_data_r;
    logic       rx_valid_r, tx_req_r, sel_start_r, sel_end_r, dir_r;
    logic [3:0] dout_r;

    // csn resets low so a select held across reset never looks like a fresh fall.
    sernor_sync #(.RST_VAL(1'b0)) u_csn_sync (
        .clk  (clk),
        .rstn (rstn),
        .pin  (spi.spi_csn),
        .rise (csn_rise_s),
        .fall (csn_fall_s)
    );

    sernor_sync #(.RST_VAL(IDLE_SCLK)) u_sclk_sync (
        .clk  (clk),
        .rstn (rstn),
        .pin  (spi.spi_sclk),
        .rise (sclk_rise_s),
        .fall (sclk_fall_s)
    );

`ifdef SERNOR_TARGET_SYNC_EN
    logic [3:0] din_meta_r, din_sync_r;

    // Data lanes take the same two-stage path so they stay aligned with sclk.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            din_meta_r <= 4'h0;
            din_sync_r <= 4'h0;
        end else begin
            din_meta_r <= spi.spi_din;
            din_sync_r <= din_meta_r;
        end
    end

    assign din_s = din_sync_r;
`else
    assign din_s = spi.spi_din;
`endif

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; csn rise wins over any same-cycle sclk edge.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (csn_fall_s) state_nxt_s = ST_ARMED;
                else            state_nxt_s = ST_IDLE;
            end
            ST_ARMED: begin
                if (csn_rise_s)       state_nxt_s = ST_IDLE;
                else if (sclk_rise_s) state_nxt_s = ST_SHIFT;
                else                  state_nxt_s = ST_ARMED;
            end
            ST_SHIFT: begin
                if (csn_rise_s) state_nxt_s = ST_IDLE;
                else            state_nxt_s = ST_SHIFT;
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State-decoded strobes; ARMED ignores falling edges (mode 3 leading edge).
    always_comb begin
        active_s    = 1'b0;
        shift_s     = 1'b0;
        sel_start_s = 1'b0;
        case (state_r)
            ST_IDLE:  sel_start_s = csn_fall_s;
            ST_ARMED: active_s = 1'b1;
            ST_SHIFT: begin
                active_s = 1'b1;
                shift_s  = 1'b1;
            end
            default: begin
                active_s = 1'b0;
                shift_s  = 1'b0;
            end
        endcase
        sel_end_s = active_s & csn_rise_s;
        rx_edge_s = active_s & sclk_rise_s & ~csn_rise_s;
        tx_edge_s = shift_s & sclk_fall_s & ~csn_rise_s;
        load_s    = sel_start_s | (tx_edge_s & done_r);
    end

    // Lane-width dependent shift values.
    always_comb begin
        wn_s       = wid_norm(wid);
        step_s     = wid_step(wn_s);
        cnt_sum_s  = {1'b0, cnt_r} + step_s;
        byte_end_s = cnt_sum_s[3];
        case (wn_s)
            SERNOR_WID_1: rx_nxt_s = {rx_sh_r[6:0], din_s[0]};
            SERNOR_WID_2: rx_nxt_s = {rx_sh_r[5:0], din_s[1:0]};
            default:      rx_nxt_s = {rx_sh_r[3:0], din_s[3:0]};
        endcase
        if (load_s) begin
            tx_nxt_s = tx_data;
        end else if (tx_edge_s) begin
            case (wn_s)
                SERNOR_WID_1: tx_nxt_s = {tx_sh_r[6:0], 1'b0};
                SERNOR_WID_2: tx_nxt_s = {tx_sh_r[5:0], 2'b00};
                default:      tx_nxt_s = {tx_sh_r[3:0], 4'h0};
            endcase
        end else begin
            tx_nxt_s = tx_sh_r;
        end
    end

    // Shift registers, bit counter and registered outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_r       <= 3'd0;
            done_r      <= 1'b0;
            rx_sh_r     <= 8'h00;
            tx_sh_r     <= 8'h00;
            rx_data_r   <= 8'h00;
            rx_valid_r  <= 1'b0;
            tx_req_r    <= 1'b0;
            sel_start_r <= 1'b0;
            sel_end_r   <= 1'b0;
            dout_r      <= 4'h0;
            dir_r       <= `IOR_DIR_IN;
        end else begin
            // Deselect drops any partial byte along with its bit count.
            if (state_nxt_s == ST_IDLE) begin
                cnt_r  <= 3'd0;
                done_r <= 1'b0;
            end else if (rx_edge_s) begin
                cnt_r  <= byte_end_s ? 3'd0 : cnt_sum_s[2:0];
                done_r <= byte_end_s | done_r;
            end else if (tx_edge_s) begin
                cnt_r  <= cnt_r;
                done_r <= 1'b0;
            end else begin
                cnt_r  <= cnt_r;
                done_r <= done_r;
            end
            rx_sh_r     <= rx_edge_s ? rx_nxt_s : rx_sh_r;
            rx_valid_r  <= rx_edge_s & byte_end_s;
            rx_data_r   <= (rx_edge_s && byte_end_s) ? rx_nxt_s : rx_data_r;
            tx_sh_r     <= tx_nxt_s;
            tx_req_r    <= load_s;
            sel_start_r <= sel_start_s;
            sel_end_r   <= sel_end_s;
            if ((state_nxt_s != ST_IDLE) && dir) begin
                dout_r <= lane_map(tx_nxt_s, wn_s);
                dir_r  <= `IOR_DIR_OUT;
            end else begin
                dout_r <= 4'h0;
                dir_r  <= `IOR_DIR_IN;
            end
        end
    end

    assign rx_data      = rx_data_r;
    assign rx_valid     = rx_valid_r;
    assign tx_req       = tx_req_r;
    assign sel_start    = sel_start_r;
    assign sel_end      = sel_end_r;
    assign spi.spi_dout = dout_r;
    assign spi.spi_dir  = dir_r;

endmodule

// File: tb/tb_sernor_target_io.sv
// Scoreboard bench for sernor_target_io: directed SPI transactions, queued expectations.
`ifndef IOR_DIR_OUT
`define IOR_DIR_OUT 1'b1
`endif
`ifndef IOR_DIR_IN
`define IOR_DIR_IN 1'b0
`endif

module tb_sernor_target_io;

    localparam int HP = 4;

    logic       clk = 1'b0;
    logic       rstn;
    logic [1:0] wid;
    logic       dir;
    logic [7:0] tx_data;
    logic [7:0] rx_data;
    logic       rx_valid, tx_req, sel_start, sel_end;

    sernor_target_io_if spi ();

    sernor_target_io dut (
        .clk       (clk),
        .rstn      (rstn),
        .spi       (spi),
        .wid       (wid),
        .dir       (dir),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .tx_data   (tx_data),
        .tx_req    (tx_req),
        .sel_start (sel_start),
        .sel_end   (sel_end)
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] rx_q[$];
    logic [3:0] lane_q[$];
    logic [7:0] rx_exp;
    logic [3:0] lane_exp;
    int         cnt_rx = 0, cnt_txreq = 0, cnt_start = 0, cnt_end = 0, dir0_bad = 0;
    logic       dir0_watch = 1'b0;
    int         r0, s0, e0, t0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor for byte-side outputs.
    always @(negedge clk) begin
        if (rx_valid === 1'b1) begin
            cnt_rx++;
            if (rx_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL rx_unexpected: got byte %h, expected no rx_valid", rx_data);
            end else begin
                rx_exp = rx_q.pop_front();
                check("rx_data", 32'(rx_data), 32'(rx_exp));
            end
        end
        if (tx_req === 1'b1)    cnt_txreq++;
        if (sel_start === 1'b1) cnt_start++;
        if (sel_end === 1'b1)   cnt_end++;
        if (dir0_watch && ((spi.spi_dir !== `IOR_DIR_IN) || (spi.spi_dout !== 4'h0))) dir0_bad++;
    end

    // Lane monitor: the initiator samples spi_dout on each rising sclk.
    always @(posedge spi.spi_sclk) begin
        if (lane_q.size() > 0) begin
            lane_exp = lane_q.pop_front();
            check("lane", 32'(spi.spi_dout), 32'(lane_exp));
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic sel();
        spi.spi_csn = 1'b0;
        wait_clk(HP);
    endtask

    task automatic desel(input logic idle);
        spi.spi_sclk = idle;
        wait_clk(HP);
        spi.spi_csn = 1'b1;
        wait_clk(2 * HP);
    endtask

    // Drives edges e0..e0+n-1 of byte b at w lanes; unused din lanes carry junk.
    task automatic edges(input logic [7:0] b, input int w, input int e0, input int n);
        logic [3:0] c;
        logic [3:0] junk;
        junk = (w == 1) ? 4'hE : ((w == 2) ? 4'hC : 4'h0);
        for (int e = e0; e < e0 + n; e++) begin
            c = 4'((int'(b) >> (8 - w * (e + 1))) & ((1 << w) - 1));
            spi.spi_sclk = 1'b0;
            spi.spi_din  = c | junk;
            wait_clk(HP);
            spi.spi_sclk = 1'b1;
            wait_clk(HP);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rx_data"},   32'(rx_data),      32'h0000_0000);
        check({tag, "_rx_valid"},  32'(rx_valid),     32'h0000_0000);
        check({tag, "_tx_req"},    32'(tx_req),       32'h0000_0000);
        check({tag, "_sel_start"}, 32'(sel_start),    32'h0000_0000);
        check({tag, "_sel_end"},   32'(sel_end),      32'h0000_0000);
        check({tag, "_dout"},      32'(spi.spi_dout), 32'h0000_0000);
        check({tag, "_dir"},       32'(spi.spi_dir),  32'(`IOR_DIR_IN));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        rstn         = 1'b0;
        spi.spi_csn  = 1'b1;
        spi.spi_sclk = 1'b0;
        spi.spi_din  = 4'h0;
        wid          = 2'd0;
        dir          = 1'b0;
        tx_data      = 8'h00;
        wait_clk(3);
        check_reset_outputs("reset");
        rstn = 1'b1;
        wait_clk(2 * HP);

        // Mode 0, single lane: receive A5, transmit C3 on lane 1.
        wid = 2'd0; dir = 1'b1; tx_data = 8'hC3;
        rx_q.push_back(8'hA5);
        lane_q.push_back(4'h2); lane_q.push_back(4'h2); lane_q.push_back(4'h0); lane_q.push_back(4'h0);
        lane_q.push_back(4'h0); lane_q.push_back(4'h0); lane_q.push_back(4'h2); lane_q.push_back(4'h2);
        s0 = cnt_start; e0 = cnt_end; r0 = cnt_rx;
        sel();
        check("dir_out_selected", 32'(spi.spi_dir), 32'(`IOR_DIR_OUT));
        edges(8'hA5, 1, 0, 7);
        check("no_rx_before_8th", 32'(cnt_rx - r0), 32'd0);
        edges(8'hA5, 1, 7, 1);
        check("rx_after_8th", 32'(cnt_rx - r0), 32'd1);
        check("rx_data_held", 32'(rx_data), 32'h0000_00A5);
        desel(1'b0);
        check("dir_in_deselected", 32'(spi.spi_dir), 32'(`IOR_DIR_IN));
        check("sel_start_pulses", 32'(cnt_start - s0), 32'd1);
        check("sel_end_pulses", 32'(cnt_end - e0), 32'd1);

        // Mode 3, quad: transmit 3C then E1, receive 96 then 7B.
        wid = 2'd2; dir = 1'b1; tx_data = 8'h3C;
        spi.spi_sclk = 1'b1;
        wait_clk(2 * HP);
        lane_q.push_back(4'h3); lane_q.push_back(4'hC); lane_q.push_back(4'hE); lane_q.push_back(4'h1);
        rx_q.push_back(8'h96); rx_q.push_back(8'h7B);
        t0 = cnt_txreq;
        sel();
        tx_data = 8'hE1;
        edges(8'h96, 4, 0, 2);
        edges(8'h7B, 4, 0, 2);
        desel(1'b1);
        check("tx_req_pulses", 32'(cnt_txreq - t0), 32'd2);
        check("lanes_drained", 32'(lane_q.size()), 32'd0);

        // Dual: abort after 2 of 4 edges, then csn rise racing a 4th edge, then 5A.
        spi.spi_sclk = 1'b0;
        wid = 2'd1;
        wait_clk(2 * HP);
        r0 = cnt_rx; e0 = cnt_end;
        sel();
        edges(8'hFF, 2, 0, 2);
        desel(1'b0);
        check("abort_no_rx", 32'(cnt_rx - r0), 32'd0);
        check("abort_sel_end", 32'(cnt_end - e0), 32'd1);
        sel();
        edges(8'hFF, 2, 0, 3);
        spi.spi_sclk = 1'b0;
        wait_clk(HP);
        spi.spi_csn  = 1'b1;
        spi.spi_sclk = 1'b1;
        wait_clk(2 * HP);
        check("csn_priority_no_rx", 32'(cnt_rx - r0), 32'd0);
        spi.spi_sclk = 1'b0;
        wait_clk(2 * HP);
        rx_q.push_back(8'h5A);
        sel();
        edges(8'h5A, 2, 0, 4);
        desel(1'b0);
        check("after_abort_rx", 32'(cnt_rx - r0), 32'd1);

        // dir=0: three bytes received while the pads never turn around.
        wid = 2'd0; dir = 1'b0; tx_data = 8'hFF;
        rx_q.push_back(8'h11); rx_q.push_back(8'h22); rx_q.push_back(8'hC7);
        dir0_watch = 1'b1;
        sel();
        edges(8'h11, 1, 0, 8);
        edges(8'h22, 1, 0, 8);
        edges(8'hC7, 1, 0, 8);
        desel(1'b0);
        dir0_watch = 1'b0;
        check("dir0_pads_quiet", 32'(dir0_bad), 32'd0);

        // Reset pulsed mid-byte with csn held low.
        wid = 2'd0; dir = 1'b1; tx_data = 8'h81;
        sel();
        check("dir_out_before_reset", 32'(spi.spi_dir), 32'(`IOR_DIR_OUT));
        edges(8'hF0, 1, 0, 3);
        rstn = 1'b0;
        wait_clk(2);
        check_reset_outputs("midreset");
        rstn = 1'b1;
        r0 = cnt_rx; e0 = cnt_end;
        edges(8'hFF, 1, 0, 8);
        spi.spi_sclk = 1'b0;
        wait_clk(HP);
        check("no_rx_after_reset", 32'(cnt_rx - r0), 32'd0);
        check("dir_in_after_reset", 32'(spi.spi_dir), 32'(`IOR_DIR_IN));
        spi.spi_csn = 1'b1;
        wait_clk(2 * HP);
        check("no_sel_end_after_reset", 32'(cnt_end - e0), 32'd0);
        rx_q.push_back(8'h3C);
        sel();
        edges(8'h3C, 1, 0, 8);
        desel(1'b0);
        check("fresh_select_rx", 32'(cnt_rx - r0), 32'd1);

        wait_clk(2 * HP);
        check("rx_drained", 32'(rx_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
